// File: rtl/key_scan.sv
// key_scan: synchronised, debounced multi-key front end with an fs/fd event port.
// Define KEY_LONG_EN to build per-key hold timers and long-press classification.
module key_scan #(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CNT = 500_000,
    parameter int LONG_CNT     = 50_000_000,
    parameter int TIMEOUT      = 50_000_000,
    localparam int ID_W        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic                fs,
    input  logic                fd,
    output logic [ID_W-1:0]     key_id,
    output logic                long_press,
    output logic                drop
);

    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CNT - 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic {IDLE, WORK} state_t;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_stable_d;
    logic [NUM_KEYS-1:0] r_pend;
    logic [31:0]         r_db_cnt [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_clr;
    logic                w_any;
    logic [ID_W-1:0]     w_sel;
    logic                w_sel_long;

    state_t          r_state;
    logic [31:0]     r_wait;
    logic            r_fs;
    logic [ID_W-1:0] r_key_id;
    logic            r_long;
    logic            r_drop;

    assign w_rise = r_stable & ~r_stable_d;

    // Lowest pending channel wins; its pend bit is cleared only when taken.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_any = 1'b1;
                w_sel = ID_W'(i);
            end
        end
        w_clr = '0;
        if (r_state == IDLE && w_any) begin
            w_clr[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_stable   <= '1;
            r_stable_d <= '1;
            r_pend     <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= key;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 32'd1;
                end
                // A new release beats the FSM taking the old event.
                if (w_rise[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

`ifdef KEY_LONG_EN
    localparam logic [31:0] LONG_SAT = 32'(LONG_CNT);

    logic [31:0]         r_hold [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_plong;
    logic [NUM_KEYS-1:0] w_fall;

    assign w_fall = ~r_stable & r_stable_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_plong <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (w_fall[i]) begin
                    r_hold[i] <= '0;
                end else if (!r_stable[i] && r_hold[i] != LONG_SAT) begin
                    r_hold[i] <= r_hold[i] + 32'd1;
                end
                if (w_rise[i]) begin
                    r_plong[i] <= (r_hold[i] >= LONG_SAT);
                end
            end
        end
    end

    assign w_sel_long = r_plong[w_sel];
`else
    assign w_sel_long = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wait   <= '0;
            r_fs     <= 1'b0;
            r_key_id <= '0;
            r_long   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wait <= '0;
                    r_drop <= 1'b0;
                    if (w_any) begin
                        r_key_id <= w_sel;
                        r_long   <= w_sel_long;
                        r_fs     <= 1'b1;
                        r_state  <= WORK;
                    end
                end
                WORK: begin
                    r_drop <= 1'b0;
                    if (fd) begin
                        r_fs    <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_wait == TO_LAST) begin
                        r_fs    <= 1'b0;
                        r_drop  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end
                default: begin
                    r_fs    <= 1'b0;
                    r_drop  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fs         = r_fs;
    assign key_id     = r_key_id;
    assign long_press = r_long;
    assign drop       = r_drop;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan: debounce, short/long press, arbitration,
// timeout and reset discard with small timing parameters.
module tb_key_scan;

    localparam bit LONG_EXP =
`ifdef KEY_LONG_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic       fd = 1'b0;
    logic       fs;
    logic [1:0] key_id;
    logic       long_press;
    logic       drop;

    int n_chk = 0;
    int n_err = 0;

    key_scan #(
        .NUM_KEYS    (4),
        .DEBOUNCE_CNT(4),
        .LONG_CNT    (20),
        .TIMEOUT     (50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .fs        (fs),
        .fd        (fd),
        .key_id    (key_id),
        .long_press(long_press),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] m, input int n);
        key = key & ~m;
        tick(n);
        key = key | m;
    endtask

    task automatic wait_fs(input string tag, input int max);
        for (int i = 0; i < max && !fs; i++) tick(1);
        chk(tag, {31'd0, fs}, 32'd1);
    endtask

    task automatic ack(input string tag);
        fd = 1'b1;
        tick(1);
        fd = 1'b0;
        chk(tag, {31'd0, fs}, 32'd0);
    endtask

    int  cnt;
    bit  seen;

    initial begin
        tick(3);
        chk("rst_fs", {31'd0, fs}, 32'd0);
        chk("rst_id", {30'd0, key_id}, 32'd0);
        chk("rst_long", {31'd0, long_press}, 32'd0);
        chk("rst_drop", {31'd0, drop}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Short press on key 1 with exact release-to-fs latency
        press(4'b0010, 10);
        tick(7);
        chk("short_early", {31'd0, fs}, 32'd0);
        tick(1);
        chk("short_fs", {31'd0, fs}, 32'd1);
        chk("short_id", {30'd0, key_id}, 32'd1);
        chk("short_long", {31'd0, long_press}, 32'd0);
        tick(2);
        chk("short_hold", {31'd0, fs}, 32'd1);
        ack("short_ack");
        chk("short_nodrop", {31'd0, drop}, 32'd0);
        tick(5);

        // Bounce rejection on key 0
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            key[0] = ~i[0];
            for (int j = 0; j < 2; j++) begin
                tick(1);
                seen = seen | fs;
            end
        end
        key[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen = seen | fs;
        end
        chk("bounce_nofs", {31'd0, seen}, 32'd0);

        // Long press on key 2
        press(4'b0100, 40);
        wait_fs("long_fs", 40);
        chk("long_id", {30'd0, key_id}, 32'd2);
        chk("long_long", {31'd0, long_press}, {31'd0, LONG_EXP});
        ack("long_ack");
        tick(5);

        // Keys 3 and 0 released together
        press(4'b1001, 10);
        wait_fs("arb_fs0", 40);
        chk("arb_id0", {30'd0, key_id}, 32'd0);
        tick(3);
        fd = 1'b1;
        tick(1);
        fd = 1'b0;
        chk("arb_gap", {31'd0, fs}, 32'd0);
        tick(1);
        chk("arb_fs1", {31'd0, fs}, 32'd1);
        chk("arb_id1", {30'd0, key_id}, 32'd3);
        ack("arb_ack");
        tick(5);

        // Timeout with no fd
        press(4'b0010, 10);
        wait_fs("to_fs", 40);
        cnt = 0;
        while (fs && cnt < 100) begin
            cnt++;
            tick(1);
        end
        chk("to_len", cnt, 32'd50);
        chk("to_drop", {31'd0, drop}, 32'd1);
        tick(1);
        chk("to_pulse", {31'd0, drop}, 32'd0);
        tick(3);

        // fd arriving on the timeout cycle wins
        press(4'b0010, 10);
        wait_fs("tofd_fs", 40);
        tick(49);
        chk("tofd_high", {31'd0, fs}, 32'd1);
        ack("tofd_ack");
        chk("tofd_nodrop", {31'd0, drop}, 32'd0);
        tick(1);
        chk("tofd_nodrop2", {31'd0, drop}, 32'd0);
        tick(3);

        // Reset while presenting key 0 with key 1 queued
        press(4'b0001, 10);
        wait_fs("rst_fs0", 40);
        press(4'b0010, 10);
        tick(10);
        chk("rst_pres", {31'd0, fs}, 32'd1);
        chk("rst_pres_id", {30'd0, key_id}, 32'd0);
        rst_n = 1'b0;
        tick(1);
        chk("rst_mid_fs", {31'd0, fs}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            seen = seen | fs;
        end
        chk("rst_discard", {31'd0, seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
